// File: rtl/execute_commit_unit_if.sv
// ============================================================================
//  Module      : execute_commit_unit_if
//  Description : Decode-to-execute control bundle and commit-side outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface execute_commit_unit_if #(
    parameter int CNT_W = 16
);
    logic             valid_IN;
    logic             input_IN;
    logic             wren_IN;
    logic [2:0]       writeAd_IN;
    logic             ADR_MUX_IN;
    logic             write_IN;
    logic             PC_load_IN;
    logic [2:0]       cond_IN;
    logic [3:0]       flags_IN;
    logic             flag_upd_IN;

    logic             input_OUT;
    logic             wren_OUT;
    logic [2:0]       writeAd_OUT;
    logic             ADR_MUX_OUT;
    logic             write_OUT;
    logic             PC_load_OUT;
    logic             flush_OUT;
    logic [3:0]       flags_OUT;
    logic [CNT_W-1:0] retired_OUT;

    modport master (
        output valid_IN, input_IN, wren_IN, writeAd_IN, ADR_MUX_IN,
               write_IN, PC_load_IN, cond_IN, flags_IN, flag_upd_IN,
        input  input_OUT, wren_OUT, writeAd_OUT, ADR_MUX_OUT, write_OUT,
               PC_load_OUT, flush_OUT, flags_OUT, retired_OUT
    );

    modport slave (
        input  valid_IN, input_IN, wren_IN, writeAd_IN, ADR_MUX_IN,
               write_IN, PC_load_IN, cond_IN, flags_IN, flag_upd_IN,
        output input_OUT, wren_OUT, writeAd_OUT, ADR_MUX_OUT, write_OUT,
               PC_load_OUT, flush_OUT, flags_OUT, retired_OUT
    );
endinterface

`default_nettype wire

// File: rtl/execute_commit_unit.sv
// ============================================================================
//  Module      : execute_commit_unit
//  Description : Branch evaluation, side-effect gating, post-branch squash
//                and retired-instruction counting for the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_commit_unit #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    execute_commit_unit_if.slave   bus
);

    localparam int c_flush_cw = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH + 1) : 1;
    localparam logic [c_flush_cw-1:0] c_depth_load = c_flush_cw'(FLUSH_DEPTH);
    localparam logic [c_flush_cw-1:0] c_cnt_one    = c_flush_cw'(1);

    typedef enum logic [0:0] {
        S_NORMAL = 1'b0,
        S_FLUSH  = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_flush_cw-1:0] r_flush_cnt;
    logic                  r_input;
    logic                  r_wren;
    logic [2:0]            r_write_ad;
    logic                  r_adr_mux;
    logic                  r_write;
    logic                  r_pc_load;
    logic                  r_flush;
    logic [3:0]            r_flags;
    logic [CNT_W-1:0]      r_retired;

    logic                  w_cond_true;
    logic                  w_commit;
    logic                  w_taken;

    // Conditions look at the architectural flags, i.e. before this
    // instruction's own flag update lands.
    always_comb begin
        w_cond_true = 1'b0;
        case (bus.cond_IN)
            3'b000:  w_cond_true = 1'b1;
            3'b001:  w_cond_true = r_flags[2];
            3'b010:  w_cond_true = ~r_flags[2];
            3'b011:  w_cond_true = r_flags[3];
            3'b100:  w_cond_true = ~r_flags[3];
            3'b101:  w_cond_true = r_flags[1];
            3'b110:  w_cond_true = ~r_flags[1];
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_commit = bus.valid_IN && (r_state == S_NORMAL);
    assign w_taken  = w_commit && bus.PC_load_IN && w_cond_true;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_NORMAL;
            r_flush_cnt <= '0;
            r_input     <= 1'b0;
            r_wren      <= 1'b0;
            r_write_ad  <= 3'b000;
            r_adr_mux   <= 1'b0;
            r_write     <= 1'b0;
            r_pc_load   <= 1'b0;
            r_flush     <= 1'b0;
            r_flags     <= 4'b0000;
            r_retired   <= '0;
        end else begin
            r_input    <= bus.input_IN;
            r_write_ad <= bus.writeAd_IN;
            r_adr_mux  <= bus.ADR_MUX_IN;
            r_wren     <= w_commit && bus.wren_IN;
            r_write    <= w_commit && bus.write_IN;
            r_pc_load  <= w_taken;

            if (w_commit && bus.flag_upd_IN) begin
                r_flags <= bus.flags_IN;
            end
            if (w_commit) begin
                r_retired <= r_retired + CNT_W'(1);
            end

            case (r_state)
                S_NORMAL: begin
                    if (w_taken && (FLUSH_DEPTH > 0)) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= c_depth_load;
                        r_flush     <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Squash window is time-based, bubbles consume it too.
                    r_flush_cnt <= r_flush_cnt - c_cnt_one;
                    if (r_flush_cnt == c_cnt_one) begin
                        r_state <= S_NORMAL;
                        r_flush <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_NORMAL;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign bus.input_OUT   = r_input;
    assign bus.wren_OUT    = r_wren;
    assign bus.writeAd_OUT = r_write_ad;
    assign bus.ADR_MUX_OUT = r_adr_mux;
    assign bus.write_OUT   = r_write;
    assign bus.PC_load_OUT = r_pc_load;
    assign bus.flush_OUT   = r_flush;
    assign bus.flags_OUT   = r_flags;
    assign bus.retired_OUT = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_execute_commit_unit.sv
// ============================================================================
//  Module      : tb_execute_commit_unit
//  Description : Bench for execute_commit_unit (depth-2/16-bit and
//                depth-0/4-bit instances driven in lockstep).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_commit_unit;

    typedef struct {
        bit         rst;
        bit         valid;
        bit         inp;
        bit         wren;
        logic [2:0] wad;
        bit         adr;
        bit         wr;
        bit         pcl;
        logic [2:0] cond;
        logic [3:0] flags;
        bit         fupd;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          e_wren;
        bit          e_wr;
        bit          e_pcl;
        bit          e_flush;
        logic [3:0]  e_flags;
        logic [15:0] e_ret;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    execute_commit_unit_if #(.CNT_W(16)) ifa ();
    execute_commit_unit_if #(.CNT_W(4))  ifb ();

    execute_commit_unit #(.FLUSH_DEPTH(2), .CNT_W(16)) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (ifa.slave)
    );

    execute_commit_unit #(.FLUSH_DEPTH(0), .CNT_W(4)) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (ifb.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: one entry per instance.
    int          depth   [2] = '{2, 0};
    int          width   [2] = '{16, 4};
    logic [3:0]  m_flags [2];
    int          m_sq    [2];
    int          m_ret   [2];
    logic [12:0] exp_o   [2];

    function automatic bit cond_true(input logic [2:0] cond, input logic [3:0] fl);
        bit n, z, c;
        n = fl[3]; z = fl[2]; c = fl[1];
        case (cond)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n;
            3'd4:    return !n;
            3'd5:    return c;
            3'd6:    return !c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input int k, input stim_t s);
        bit commit, taken;
        if (s.rst) begin
            m_flags[k] = 4'h0;
            m_sq[k]    = 0;
            m_ret[k]   = 0;
            exp_o[k]   = '0;
        end else begin
            commit = s.valid && (m_sq[k] == 0);
            taken  = commit && s.pcl && cond_true(s.cond, m_flags[k]);
            if (m_sq[k] > 0)  m_sq[k] = m_sq[k] - 1;
            else if (taken)   m_sq[k] = depth[k];
            if (commit && s.fupd) m_flags[k] = s.flags;
            if (commit) m_ret[k] = (m_ret[k] + 1) % (1 << width[k]);
            exp_o[k] = {s.inp, commit && s.wren, s.wad, s.adr, commit && s.wr,
                        taken, (m_sq[k] > 0), m_flags[k]};
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic apply(input stim_t s);
        rst              = s.rst;
        ifa.valid_IN     = s.valid;  ifb.valid_IN     = s.valid;
        ifa.input_IN     = s.inp;    ifb.input_IN     = s.inp;
        ifa.wren_IN      = s.wren;   ifb.wren_IN      = s.wren;
        ifa.writeAd_IN   = s.wad;    ifb.writeAd_IN   = s.wad;
        ifa.ADR_MUX_IN   = s.adr;    ifb.ADR_MUX_IN   = s.adr;
        ifa.write_IN     = s.wr;     ifb.write_IN     = s.wr;
        ifa.PC_load_IN   = s.pcl;    ifb.PC_load_IN   = s.pcl;
        ifa.cond_IN      = s.cond;   ifb.cond_IN      = s.cond;
        ifa.flags_IN     = s.flags;  ifb.flags_IN     = s.flags;
        ifa.flag_upd_IN  = s.fupd;   ifb.flag_upd_IN  = s.fupd;
        model_step(0, s);
        model_step(1, s);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] pack_a();
        return {ifa.input_OUT, ifa.wren_OUT, ifa.writeAd_OUT, ifa.ADR_MUX_OUT,
                ifa.write_OUT, ifa.PC_load_OUT, ifa.flush_OUT, ifa.flags_OUT};
    endfunction

    function automatic logic [12:0] pack_b();
        return {ifb.input_OUT, ifb.wren_OUT, ifb.writeAd_OUT, ifb.ADR_MUX_OUT,
                ifb.write_OUT, ifb.PC_load_OUT, ifb.flush_OUT, ifb.flags_OUT};
    endfunction

    task automatic check_models();
        check("a_outputs_vs_model", 32'(pack_a()), 32'(exp_o[0]));
        check("a_retired_vs_model", 32'(ifa.retired_OUT), 32'(m_ret[0]));
        check("b_outputs_vs_model", 32'(pack_b()), 32'(exp_o[1]));
        check("b_retired_vs_model", 32'(ifb.retired_OUT), 32'(m_ret[1]));
    endtask

    function automatic vec_t mk(bit r, bit v, bit inp, bit we, logic [2:0] wad, bit adr,
                                bit wr, bit pcl, logic [2:0] cond, logic [3:0] fl, bit fu,
                                bit ewe, bit ewr, bit epc, bit efl, logic [3:0] efg,
                                logic [15:0] eret);
        vec_t x;
        x.s = '{rst: r, valid: v, inp: inp, wren: we, wad: wad, adr: adr, wr: wr,
                pcl: pcl, cond: cond, flags: fl, fupd: fu};
        x.e_wren = ewe; x.e_wr = ewr; x.e_pcl = epc; x.e_flush = efl;
        x.e_flags = efg; x.e_ret = eret;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        stim_t      s;
        logic [4:0] pt;

        // Reset with every input high, then basic commit
        vecs.push_back(mk(1,1,1,1,3'd7,1,1,1,3'd0,4'hF,1, 0,0,0,0,4'h0,0));
        vecs.push_back(mk(1,1,1,1,3'd7,1,1,1,3'd0,4'hF,1, 0,0,0,0,4'h0,0));
        vecs.push_back(mk(0,1,0,1,3'd5,0,1,0,3'd0,4'h0,0, 1,1,0,0,4'h0,1));
        // Preload Z=1, then not-taken conditions (111, !Z, N, C)
        vecs.push_back(mk(0,1,1,0,3'd1,1,0,0,3'd0,4'h4,1, 0,0,0,0,4'h4,2));
        vecs.push_back(mk(0,1,0,1,3'd3,0,0,1,3'd7,4'h0,0, 1,0,0,0,4'h4,3));
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,1,3'd2,4'h0,0, 0,0,0,0,4'h4,4));
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,1,3'd3,4'h0,0, 0,0,0,0,4'h4,5));
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,1,3'd5,4'h0,0, 0,0,0,0,4'h4,6));
        // Taken on Z, two squashed instructions (one tries a flag update), third commits
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,1,3'd1,4'h0,0, 0,0,1,1,4'h4,7));
        vecs.push_back(mk(0,1,0,1,3'd6,0,1,0,3'd0,4'h0,1, 0,0,0,1,4'h4,7));
        vecs.push_back(mk(0,1,0,1,3'd6,0,1,0,3'd0,4'h0,0, 0,0,0,0,4'h4,7));
        vecs.push_back(mk(0,1,0,1,3'd6,0,0,0,3'd0,4'h0,0, 1,0,0,0,4'h4,8));
        // Always, !N, !C taken; bubbles during flush
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,1,3'd0,4'h0,0, 0,0,1,1,4'h4,9));
        vecs.push_back(mk(0,0,0,1,3'd0,0,1,0,3'd0,4'h0,0, 0,0,0,1,4'h4,9));
        vecs.push_back(mk(0,0,0,1,3'd0,0,1,0,3'd0,4'h0,0, 0,0,0,0,4'h4,9));
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,1,3'd4,4'h0,0, 0,0,1,1,4'h4,10));
        vecs.push_back(mk(0,0,0,0,3'd0,0,0,0,3'd0,4'h0,0, 0,0,0,1,4'h4,10));
        vecs.push_back(mk(0,0,0,1,3'd0,0,1,0,3'd0,4'h0,0, 0,0,0,0,4'h4,10));
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,1,3'd6,4'h0,0, 0,0,1,1,4'h4,11));
        vecs.push_back(mk(0,0,0,0,3'd0,0,0,0,3'd0,4'h0,0, 0,0,0,1,4'h4,11));
        vecs.push_back(mk(0,0,0,0,3'd0,0,0,0,3'd0,4'h0,0, 0,0,0,0,4'h4,11));
        // Flag ordering: old Z=0, same instruction sets Z and branches on Z
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,0,3'd0,4'h0,1, 0,0,0,0,4'h0,12));
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,1,3'd1,4'h4,1, 0,0,0,0,4'h4,13));
        // Reset during the first flush cycle
        vecs.push_back(mk(0,1,0,0,3'd0,0,0,1,3'd0,4'h0,0, 0,0,1,1,4'h4,14));
        vecs.push_back(mk(1,1,0,1,3'd0,0,0,0,3'd0,4'h0,0, 0,0,0,0,4'h0,0));
        vecs.push_back(mk(0,1,0,1,3'd2,0,0,0,3'd0,4'h0,0, 1,0,0,0,4'h0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].s);
            pt = vecs[i].s.rst ? 5'd0 : {vecs[i].s.inp, vecs[i].s.wad, vecs[i].s.adr};
            check($sformatf("vec%0d_wren", i),    32'(ifa.wren_OUT),    32'(vecs[i].e_wren));
            check($sformatf("vec%0d_write", i),   32'(ifa.write_OUT),   32'(vecs[i].e_wr));
            check($sformatf("vec%0d_pc_load", i), 32'(ifa.PC_load_OUT), 32'(vecs[i].e_pcl));
            check($sformatf("vec%0d_flush", i),   32'(ifa.flush_OUT),   32'(vecs[i].e_flush));
            check($sformatf("vec%0d_flags", i),   32'(ifa.flags_OUT),   32'(vecs[i].e_flags));
            check($sformatf("vec%0d_retired", i), 32'(ifa.retired_OUT), 32'(vecs[i].e_ret));
            check($sformatf("vec%0d_passthru", i),
                  32'({ifa.input_OUT, ifa.writeAd_OUT, ifa.ADR_MUX_OUT}), 32'(pt));
            check("b_outputs_vs_model", 32'(pack_b()), 32'(exp_o[1]));
            check("b_retired_vs_model", 32'(ifb.retired_OUT), 32'(m_ret[1]));
        end

        // Counter wrap on the 4-bit instance: 17 commits -> 1..15, 0, 1
        s = '{rst: 1, valid: 0, inp: 0, wren: 0, wad: 3'd0, adr: 0, wr: 0,
              pcl: 0, cond: 3'd0, flags: 4'h0, fupd: 0};
        apply(s);
        check("wrap_reset_b", 32'(ifb.retired_OUT), 32'd0);
        s.rst = 0; s.valid = 1; s.wren = 1;
        for (int k = 1; k <= 17; k++) begin
            apply(s);
            check($sformatf("wrap_b_%0d", k), 32'(ifb.retired_OUT), 32'(k % 16));
            check($sformatf("wrap_a_%0d", k), 32'(ifa.retired_OUT), 32'(k));
        end

        // Randomised traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            s.rst   = ($urandom_range(0, 59) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.inp   = 1'($urandom);
            s.wren  = 1'($urandom);
            s.wad   = 3'($urandom);
            s.adr   = 1'($urandom);
            s.wr    = 1'($urandom);
            s.pcl   = ($urandom_range(0, 2) == 0);
            s.cond  = 3'($urandom);
            s.flags = 4'($urandom);
            s.fupd  = ($urandom_range(0, 2) == 0);
            apply(s);
            check_models();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
